// File: rtl/and2_rr_arbiter.sv
// Round-robin arbiter sharing one bitwise AND datapath between N requesters,
// with a registered single-entry result slot. Define AND2_RR_ARBITER_COUNT_EN to add OP_COUNT.
module and2_rr_arbiter #(
    parameter int WIDTH = 2,
    parameter int N     = 4,
    localparam int IDW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic [N-1:0]         REQ_VALID,
    output logic [N-1:0]         REQ_READY,
    input  logic [N*WIDTH-1:0]   I0,
    input  logic [N*WIDTH-1:0]   I1,
    output logic [WIDTH-1:0]     O,
    output logic                 O_VALID,
    input  logic                 O_READY,
    output logic [IDW-1:0]       O_ID
`ifdef AND2_RR_ARBITER_COUNT_EN
    ,
    output logic [15:0]          OP_COUNT
`else
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    localparam logic [IDW:0]   NUM  = (IDW + 1)'(N);
    localparam logic [IDW-1:0] LAST = IDW'(N - 1);

    slot_state_t      state;
    slot_state_t      next_state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   first;
    logic [IDW:0]     grant_sum;
    logic [2*N-1:0]   doubled;
    logic [N-1:0]     rot_low;
    logic             any_valid;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    assign O_VALID    = (state == S_FULL);
    assign any_valid  = |REQ_VALID;
    assign can_accept = !O_VALID || O_READY;
    assign accept     = any_valid && can_accept && !ASYNCRESET;

    // Rotate requests so the pointer position sits at bit 0, then take the lowest set bit.
    assign doubled = {REQ_VALID, REQ_VALID};
    assign rot_low = N'(doubled >> ptr);

    always_comb begin
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_low[i]) begin
                first = IDW'(i);
            end
        end
    end

    assign grant_sum = {1'b0, ptr} + {1'b0, first};

    always_comb begin
        if (grant_sum >= NUM) begin
            grant = IDW'(grant_sum - NUM);
        end else begin
            grant = grant_sum[IDW-1:0];
        end
    end

    always_comb begin
        REQ_READY = '0;
        if (accept) begin
            REQ_READY[grant] = 1'b1;
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == grant) begin
                op_a = I0[i*WIDTH +: WIDTH];
                op_b = I1[i*WIDTH +: WIDTH];
            end
        end
    end

    // A new accept keeps the slot full even while the old result drains.
    always_comb begin
        next_state = state;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    next_state = S_FULL;
                end
            end
            S_FULL: begin
                if (accept) begin
                    next_state = S_FULL;
                end else if (O_READY) begin
                    next_state = S_EMPTY;
                end
            end
            default: next_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state <= S_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            O    <= '0;
            O_ID <= '0;
            ptr  <= '0;
        end else if (accept) begin
            O    <= op_a & op_b;
            O_ID <= grant;
            ptr  <= (grant == LAST) ? '0 : grant + 1'b1;
        end
    end

`ifdef AND2_RR_ARBITER_COUNT_EN
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            OP_COUNT <= '0;
        end else if (O_VALID && O_READY && (OP_COUNT != 16'hFFFF)) begin
            OP_COUNT <= OP_COUNT + 16'd1;
        end
    end
`else
`endif

endmodule
